int_ctrl: RTL

Interrupt controller for the interrupt-capable five-stage pipeline. It synchronizes and edge-detects three external interrupt lines and holds them as pending requests. It arbitrates by fixed priority and raises an entry request with the chosen source and handler vector toward the fetch stage. It also consumes the MEM-stage interrupt and CSR signals (Int_Enter, uret, IEWrite, EPCWrite, IRS) to update the pending, in-service, IE and EPC state.

---
 rtl/int_pkg.sv | 42 ++++
 rtl/irq_sync_edge.sv | 37 +++
 rtl/int_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// source count, one-hot to index conversion and highest-set-bit priority pick.
package int_pkg;

    localparam int NUM_IRQ = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_IRQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Keeps only the most significant set bit; bit NUM_IRQ-1 has top priority.
    function automatic logic [NUM_IRQ-1:0] highest_set(input logic [NUM_IRQ-1:0] v);
        logic [NUM_IRQ-1:0] r;
        logic               found;
        r     = {NUM_IRQ{1'b0}};
        found = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer per line followed by a third flop for rising-edge
// detection; rise is a one-cycle pulse in the clk domain.
module irq_sync_edge #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] s1_d, s2_d, s3_d;

    // Next-state of the synchronizer chain
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and edge-history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= {W{1'b0}};
            s2_q <= {W{1'b0}};
            s3_q <= {W{1'b0}};
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending/in-service tracking, fixed-priority request FSM,
// IE/EPC registers. Define INT_NESTING_EN to allow higher-priority nesting.
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0100,
    parameter logic             IE_RESET   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         irq,
    input  logic               Int_Enter_mem,
    input  logic [2:0]         IRS_mem,
    input  logic               uret_mem,
    input  logic               IEWrite_mem,
    input  logic               IEWriteData_mem,
    input  logic               EPCWrite_mem,
    input  logic [WIDTH-1:0]   EPCWriteData_mem,
    output logic               int_req,
    output logic [2:0]         IRS_out,
    output logic [WIDTH-1:0]   int_vector,
    output logic               IE_out,
    output logic [WIDTH-1:0]   EPC_out,
    output logic [2:0]         in_service
);

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic               ie_q, ie_d;
    logic [WIDTH-1:0]   epc_q, epc_d;

    state_e             state_q;
    logic [NUM_IRQ-1:0] irs_q;
    logic               int_req_q;
    logic [WIDTH-1:0]   vec_q;

    logic               enter_ev;
    logic [NUM_IRQ-1:0] svc_after_uret;
    logic [NUM_IRQ-1:0] cand;
    logic [WIDTH-1:0]   cand_vec;
    logic               eligible;
    logic               entry_match;

    irq_sync_edge #(.W(NUM_IRQ)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (irq),
        .rise     (rise)
    );

    // MEM-side state updates; uret clear is applied before the entry set
    always_comb begin
        enter_ev  = en && Int_Enter_mem;
        pending_d = (pending_q & ~(enter_ev ? IRS_mem : 3'b000)) | rise;
        if (en && uret_mem) begin
            svc_after_uret = in_service_q & ~highest_set(in_service_q);
        end else begin
            svc_after_uret = in_service_q;
        end
        in_service_d = svc_after_uret | (enter_ev ? IRS_mem : 3'b000);
        ie_d  = (en && IEWrite_mem)  ? IEWriteData_mem  : ie_q;
        epc_d = (en && EPCWrite_mem) ? EPCWriteData_mem : epc_q;
    end

    // Arbitration: candidate is the highest pending source
    always_comb begin
        cand        = highest_set(pending_q);
        cand_vec    = VEC_BASE + (WIDTH'(onehot_to_idx(cand)) * VEC_STRIDE);
        entry_match = enter_ev && (IRS_mem == irs_q);
`ifdef INT_NESTING_EN
        eligible = ie_q && (cand > highest_set(in_service_q));
`else
        eligible = ie_q && (in_service_q == 3'b000) && (cand != 3'b000);
`endif
    end

    // Pending, in-service, IE and EPC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= 3'b000;
            in_service_q <= 3'b000;
            ie_q         <= IE_RESET;
            epc_q        <= {WIDTH{1'b0}};
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            ie_q         <= ie_d;
            epc_q        <= epc_d;
        end
    end

    // Request FSM; source is frozen for the whole REQ phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            irs_q     <= 3'b000;
            int_req_q <= 1'b0;
            vec_q     <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible) begin
                        state_q   <= REQ;
                        irs_q     <= cand;
                        int_req_q <= 1'b1;
                        vec_q     <= cand_vec;
                    end else begin
                        state_q   <= IDLE;
                        irs_q     <= 3'b000;
                        int_req_q <= 1'b0;
                        vec_q     <= {WIDTH{1'b0}};
                    end
                end
                REQ: begin
                    if (entry_match) begin
                        state_q   <= IDLE;
                        irs_q     <= 3'b000;
                        int_req_q <= 1'b0;
                        vec_q     <= {WIDTH{1'b0}};
                    end else begin
                        state_q   <= REQ;
                        irs_q     <= irs_q;
                        int_req_q <= 1'b1;
                        vec_q     <= vec_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    irs_q     <= 3'b000;
                    int_req_q <= 1'b0;
                    vec_q     <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign int_req    = int_req_q;
    assign IRS_out    = irs_q;
    assign int_vector = vec_q;
    assign IE_out     = ie_q;
    assign EPC_out    = epc_q;
    assign in_service = in_service_q;

endmodule
